cube_sched: RTL and testbench
=============================

CUBE_SCHED -- requirements
Module: cube_sched

Interface
REQ-001 SHALL have parameter: MUL_LAT, default 1, cycles the shared multiplier needs per product; legal range 1..8.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk     in   1   single clock; all state updates on rising edge
  rst     in   1   reset, asynchronous, active-high
  req     in   2   per-requester one-cycle request pulse
  op0     in   32  operand of requester 0, sampled when req[0]=1
  op1     in   32  operand of requester 1, sampled when req[1]=1
  gnt     out  2   one-hot pulse, one cycle: requester whose job starts
  done    out  2   one-hot pulse, one cycle: requester whose job completes
  result  out  32  cube of the completed job's operand, valid while done!=0
  busy    out  1   high whenever state is not IDLE
  ovf     out  2   sticky per-requester dropped-request flag
  mul_a   out  32  shared multiplier operand A
  mul_b   out  32  shared multiplier operand B
  mul_p   in   32  low 32 bits of mul_a*mul_b, valid MUL_LAT cycles after operands are stable
REQ-003 SHALL use only clk and rst; no other clock or reset.

Function
REQ-004 SHALL keep per requester i a pending[i] bit and 32-bit buffer opbuf[i]; req[i]=1 with pending[i]=0 sets pending[i] and captures op_i into opbuf[i].
REQ-005 SHALL ignore req[i] while pending[i]=1 (opbuf unchanged) and set ovf[i]=1; ovf clears only on reset.
REQ-006 SHALL, in the DONE cycle of requester i, accept req[i] as new (set wins over clear, no ovf).
REQ-007 SHALL implement FSM IDLE -> SQ -> CU -> DONE -> IDLE; no other states.
REQ-008 IDLE: if any pending bit set, select requester, load x=opbuf[sel], pulse gnt[sel], go to SQ; else stay IDLE.
REQ-009 Arbitration: round-robin via last-granted register; single pending wins; both pending -> requester not last granted; last-granted reset value 1 (requester 0 wins first tie).
REQ-010 SQ: drive mul_a=mul_b=x for exactly MUL_LAT cycles; on the last, register sq=mul_p, go to CU.
REQ-011 CU: drive mul_a=sq, mul_b=x for exactly MUL_LAT cycles; on the last, register result=mul_p, go to DONE.
REQ-012 DONE: one cycle; done[sel]=1, clear pending[sel] (subject to REQ-006); next state IDLE.
REQ-013 mul_a and mul_b SHALL be 0 in IDLE and DONE.
REQ-014 Arithmetic SHALL be unsigned, truncated to 32 bits at each product (result = x^3 mod 2^32).
REQ-015 Latency: req[i] at edge E0 on an idle block -> gnt[i] high after E1, done[i] high after E(2+2*MUL_LAT) for one cycle.
REQ-016 result SHALL hold its value until the next DONE; gnt and done SHALL never have more than one bit set.
REQ-017 A requester's second job SHALL not start before the other's pending job when both are pending (no starvation).

Reset
REQ-018 rst=1 SHALL immediately force state IDLE, pending=0, ovf=0, gnt=0, done=0, result=0, busy=0, mul_a=mul_b=0, last-granted=1, regardless of operation in progress.
REQ-019 A job interrupted by reset SHALL be discarded; no done pulse for it after rst deasserts.

Verification
REQ-020 MUL_LAT=1, req[0] op0=3 at E0 -> gnt=01 after E1, done=01 after E4, result=27, busy low after E5.
REQ-021 req[0] op0=5 and req[1] op1=2 same cycle -> requester 0 first (result 125), then requester 1 (result 8); next tie goes to requester 0 again only after requester 1 has been granted.
REQ-022 op0=0x00000800 -> result 0x00000000; op0=0xFFFFFFFF -> result 0xFFFFFFFF (wrap-around).
REQ-023 req[1] pulsed twice while pending[1]=1 -> only first operand computed, ovf=10 sticky; req[1] in its DONE cycle -> accepted, ovf unchanged.
REQ-024 MUL_LAT=4, op1=7 -> mul_a/mul_b stable 4 cycles per pass, done after E10, result=343.
REQ-025 rst pulsed during CU -> all outputs 0 at once, no done pulse follows; fresh req[0] op0=2 afterwards -> result 8 with nominal latency.

Source files
------------

// File: rtl/cube_sched.sv
// cube_sched
// Two-requester scheduler that computes x^3 (mod 2^32) on a shared external
// multiplier. Each requester has a one-entry buffer; a round-robin arbiter
// picks the next job, which makes two passes through the multiplier
// (x*x, then sq*x) before the result is presented with a one-cycle done pulse.
//
// Parameters
//   MUL_LAT  cycles the external multiplier needs per product (1..8)
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   req[1:0]       per-requester request pulse
//   op0, op1       operands, sampled when the matching req bit is accepted
//   gnt[1:0]       one-hot pulse: job of this requester starts
//   done[1:0]      one-hot pulse: job of this requester completes
//   result[31:0]   cube of the completed operand, held until the next done
//   busy           scheduler is not idle
//   ovf[1:0]       sticky: a request arrived while that requester was pending
//   mul_a, mul_b   shared multiplier operands (0 when not multiplying)
//   mul_p          low 32 bits of mul_a*mul_b, MUL_LAT cycles after operands
module cube_sched #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] op0,
    input  logic [31:0] op1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] result,
    output logic        busy,
    output logic [1:0]  ovf,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_p
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQ   = 2'd1,
        S_CU   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       pending_q, pending_d;
    logic [1:0]       ovf_q, ovf_d;
    logic [31:0]      opbuf_q [2];
    logic [31:0]      opbuf_d [2];
    logic [31:0]      op_in   [2];
    logic [31:0]      x_q, x_d;
    logic [31:0]      sq_q, sq_d;
    logic [31:0]      result_q, result_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick;
    logic             beat_end;

    assign op_in[0] = op0;
    assign op_in[1] = op1;

    // The product is sampled on the final cycle of each multiplier pass.
    assign beat_end = (cnt_q == LAST_BEAT);

    // Round-robin: a lone pending requester wins; on a tie the requester
    // that was not granted last goes first.
    always_comb begin
        pick = pending_q[1];
        if (pending_q == 2'b11) begin
            pick = ~last_q;
        end
    end

    // Per-requester request buffer. A request in the DONE cycle of the same
    // requester is taken as a new job (set beats clear) and is not an overflow.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic clear_i;
            logic accept_i;

            assign clear_i        = (state_q == S_DONE) && (sel_q == 1'(gi));
            assign accept_i       = req[gi] && (!pending_q[gi] || clear_i);
            assign pending_d[gi]  = accept_i || (pending_q[gi] && !clear_i);
            assign ovf_d[gi]      = ovf_q[gi] || (req[gi] && !accept_i);
            assign opbuf_d[gi]    = accept_i ? op_in[gi] : opbuf_q[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opbuf_q[gi] <= '0;
                end else begin
                    opbuf_q[gi] <= opbuf_d[gi];
                end
            end
        end
    endgenerate

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        sq_d     = sq_q;
        result_d = result_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt      = 2'b00;
        done     = 2'b00;
        mul_a    = '0;
        mul_b    = '0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != 2'b00) begin
                    sel_d     = pick;
                    last_d    = pick;
                    x_d       = opbuf_q[pick];
                    gnt[pick] = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_SQ;
                end
            end
            S_SQ: begin
                mul_a = x_q;
                mul_b = x_q;
                if (beat_end) begin
                    sq_d    = mul_p;
                    cnt_d   = '0;
                    state_d = S_CU;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CU: begin
                mul_a = sq_q;
                mul_b = x_q;
                if (beat_end) begin
                    result_d = mul_p;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done[sel_q] = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 2'b00;
            ovf_q     <= 2'b00;
            x_q       <= '0;
            sq_q      <= '0;
            result_q  <= '0;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            x_q       <= x_d;
            sq_q      <= sq_d;
            result_q  <= result_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != S_IDLE);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_cube_sched.sv
// Testbench for cube_sched: one instance with MUL_LAT=1 (combinational
// multiplier model) and one with MUL_LAT=4 (multiplier model with a 3-stage
// operand pipeline, so an early capture sees stale operands).
module tb_cube_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // MUL_LAT = 1 instance signals
    logic [1:0]  req1, gnt1, done1, ovf1;
    logic [31:0] op0_1, op1_1, result1, mul_a1, mul_b1, mul_p1;
    logic        busy1;
    // MUL_LAT = 4 instance signals
    logic [1:0]  req4, gnt4, done4, ovf4;
    logic [31:0] op0_4, op1_4, result4, mul_a4, mul_b4, mul_p4;
    logic        busy4;

    cube_sched #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .op0(op0_1), .op1(op1_1),
        .gnt(gnt1), .done(done1), .result(result1), .busy(busy1), .ovf(ovf1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1)
    );

    cube_sched #(.MUL_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .op0(op0_4), .op1(op1_4),
        .gnt(gnt4), .done(done4), .result(result4), .busy(busy4), .ovf(ovf4),
        .mul_a(mul_a4), .mul_b(mul_b4), .mul_p(mul_p4)
    );

    // Multiplier models
    assign mul_p1 = mul_a1 * mul_b1;

    logic [31:0] a4_s [3];
    logic [31:0] b4_s [3];
    always @(posedge clk) begin
        a4_s[0] <= mul_a4;
        b4_s[0] <= mul_b4;
        a4_s[1] <= a4_s[0];
        b4_s[1] <= b4_s[0];
        a4_s[2] <= a4_s[1];
        b4_s[2] <= b4_s[1];
    end
    assign mul_p4 = a4_s[2] * b4_s[2];

    // Scoreboard
    typedef struct {
        logic [1:0]  who;
        logic [31:0] res;
    } sb_t;

    sb_t q1[$];
    sb_t q4[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [1:0] who, input logic [31:0] res);
        sb_t e;
        e.who = who;
        e.res = res;
        q1.push_back(e);
    endtask

    task automatic push4(input logic [1:0] who, input logic [31:0] res);
        sb_t e;
        e.who = who;
        e.res = res;
        q4.push_back(e);
    endtask

    // Wait until the given scoreboard drains; an expired budget is a failure.
    task automatic wait_drain(input int which, input int budget);
        int left;
        int outstanding;
        left = budget;
        outstanding = (which == 1) ? q1.size() : q4.size();
        while (outstanding != 0 && left > 0) begin
            @(posedge clk);
            left--;
            outstanding = (which == 1) ? q1.size() : q4.size();
        end
        if (outstanding != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_dut%0d: %0d results outstanding after %0d cycles, required 0",
                     which, outstanding, budget);
            if (which == 1) q1.delete();
            else q4.delete();
        end
        tick();
        tick();
    endtask

    // Output monitors: one line per completed job, compared against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt1 != 2'b00) check("gnt1_onehot", 32'($onehot(gnt1)), 32'd1);
            if (done1 != 2'b00) begin
                $display("dut1 done=%b result=0x%08h", done1, result1);
                if (q1.size() == 0) begin
                    check("done1_unexpected", 32'(done1), 32'd0);
                end else begin
                    sb_t e;
                    e = q1.pop_front();
                    check("done1_who", 32'(done1), 32'(e.who));
                    check("result1", result1, e.res);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (gnt4 != 2'b00) check("gnt4_onehot", 32'($onehot(gnt4)), 32'd1);
            if (done4 != 2'b00) begin
                $display("dut4 done=%b result=0x%08h", done4, result4);
                if (q4.size() == 0) begin
                    check("done4_unexpected", 32'(done4), 32'd0);
                end else begin
                    sb_t e;
                    e = q4.pop_front();
                    check("done4_who", 32'(done4), 32'(e.who));
                    check("result4", result4, e.res);
                end
            end
        end
    end

    // Table of single and tied requests (MUL_LAT=1). Tie order follows the
    // grant history of the preceding rows.
    typedef struct {
        logic [1:0]  req;
        logic [31:0] op0;
        logic [31:0] op1;
        int          n;
        logic [1:0]  who_a;
        logic [31:0] res_a;
        logic [1:0]  who_b;
        logic [31:0] res_b;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic seen;

        vt[0] = '{2'b01, 32'd3,          32'd0,          1, 2'b01, 32'd27,         2'b00, 32'd0};
        vt[1] = '{2'b10, 32'd0,          32'd5,          1, 2'b10, 32'd125,        2'b00, 32'd0};
        vt[2] = '{2'b11, 32'd5,          32'd2,          2, 2'b01, 32'd125,        2'b10, 32'd8};
        vt[3] = '{2'b11, 32'd4,          32'd6,          2, 2'b01, 32'd64,         2'b10, 32'd216};
        vt[4] = '{2'b01, 32'h0000_0800,  32'd0,          1, 2'b01, 32'h0000_0000,  2'b00, 32'd0};
        vt[5] = '{2'b11, 32'd7,          32'd3,          2, 2'b10, 32'd27,         2'b01, 32'd343};
        vt[6] = '{2'b10, 32'd0,          32'hFFFF_FFFF,  1, 2'b10, 32'hFFFF_FFFF,  2'b00, 32'd0};
        vt[7] = '{2'b01, 32'h0001_0001,  32'd0,          1, 2'b01, 32'h0003_0001,  2'b00, 32'd0};
        vt[8] = '{2'b01, 32'hFFFF_FFFF,  32'd0,          1, 2'b01, 32'hFFFF_FFFF,  2'b00, 32'd0};
        vt[9] = '{2'b11, 32'h0000_0800,  32'hFFFF_FFFF,  2, 2'b10, 32'hFFFF_FFFF,  2'b01, 32'h0000_0000};

        req1 = 2'b00; op0_1 = '0; op1_1 = '0;
        req4 = 2'b00; op0_4 = '0; op1_4 = '0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_gnt",    32'(gnt1),  32'd0);
        check("rst_done",   32'(done1), 32'd0);
        check("rst_result", result1,    32'd0);
        check("rst_busy",   32'(busy1), 32'd0);
        check("rst_ovf",    32'(ovf1),  32'd0);
        check("rst_mul_a",  mul_a1,     32'd0);
        check("rst_mul_b",  mul_b1,     32'd0);
        check("rst_busy4",  32'(busy4), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Nominal latency, MUL_LAT=1, op0=3
        tick(); req1 = 2'b01; op0_1 = 32'd3; push1(2'b01, 32'd27);      // E0
        tick(); req1 = 2'b00;                                           // E1
        check("lat_gnt_E1",  32'(gnt1),  32'h1);
        check("lat_busy_E1", 32'(busy1), 32'd0);
        tick();                                                         // E2
        check("lat_gnt_E2",  32'(gnt1),  32'd0);
        check("lat_sq_a",    mul_a1,     32'd3);
        check("lat_sq_b",    mul_b1,     32'd3);
        tick();                                                         // E3
        check("lat_cu_a",    mul_a1,     32'd9);
        check("lat_cu_b",    mul_b1,     32'd3);
        check("lat_done_E3", 32'(done1), 32'd0);
        tick();                                                         // E4
        check("lat_done_E4", 32'(done1), 32'h1);
        check("lat_res_E4",  result1,    32'd27);
        check("lat_mul_done", mul_a1,    32'd0);
        tick();                                                         // E5
        check("lat_busy_E5", 32'(busy1), 32'd0);
        check("lat_done_E5", 32'(done1), 32'd0);
        check("lat_res_hold", result1,   32'd27);
        wait_drain(1, 20);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            tick();
            req1 = vt[i].req; op0_1 = vt[i].op0; op1_1 = vt[i].op1;
            push1(vt[i].who_a, vt[i].res_a);
            if (vt[i].n == 2) push1(vt[i].who_b, vt[i].res_b);
            tick();
            req1 = 2'b00;
            wait_drain(1, 40);
        end

        // Overflow: repeat requests while pending, then a request in DONE
        tick(); req1 = 2'b10; op1_1 = 32'd9;                            // E0
        push1(2'b10, 32'd729);
        push1(2'b10, 32'd64);
        tick(); op1_1 = 32'd100;                                        // E1
        check("ovf_first_accepted", 32'(ovf1), 32'd0);
        tick(); req1 = 2'b00;                                           // E2
        check("ovf_set", 32'(ovf1), 32'h2);
        tick(); req1 = 2'b10; op1_1 = 32'd200;                          // E3
        tick();                                                         // E4
        check("ovf_done_cycle", 32'(done1), 32'h2);
        op1_1 = 32'd4;
        tick(); req1 = 2'b00;                                           // E5
        check("ovf_unchanged_done_req", 32'(ovf1), 32'h2);
        check("ovf_regrant", 32'(gnt1), 32'h2);
        wait_drain(1, 40);
        check("ovf_sticky", 32'(ovf1), 32'h2);

        // Reset during CU discards the job
        tick(); req1 = 2'b01; op0_1 = 32'd6;                            // E0
        tick(); req1 = 2'b00;                                           // E1
        check("rstcu_gnt", 32'(gnt1), 32'h1);
        tick();                                                         // E2
        tick();                                                         // E3
        check("rstcu_busy",  32'(busy1), 32'd1);
        check("rstcu_mul_a", mul_a1,     32'd36);
        check("rstcu_mul_b", mul_b1,     32'd6);
        check("rstcu_res_before", result1, 32'd64);
        rst = 1'b1;
        #1;
        check("rstcu_busy0",  32'(busy1), 32'd0);
        check("rstcu_mul_a0", mul_a1,     32'd0);
        check("rstcu_mul_b0", mul_b1,     32'd0);
        check("rstcu_result0", result1,   32'd0);
        check("rstcu_ovf0",   32'(ovf1),  32'd0);
        check("rstcu_gnt0",   32'(gnt1),  32'd0);
        check("rstcu_done0",  32'(done1), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done1 != 2'b00) seen = 1'b1;
        end
        check("rstcu_no_stale_done", 32'(seen), 32'd0);
        tick(); req1 = 2'b01; op0_1 = 32'd2; push1(2'b01, 32'd8);       // E0
        tick(); req1 = 2'b00;                                           // E1
        check("post_rst_gnt", 32'(gnt1), 32'h1);
        tick(); tick(); tick();                                         // E4
        check("post_rst_done", 32'(done1), 32'h1);
        check("post_rst_res",  result1,    32'd8);
        tick();                                                         // E5
        check("post_rst_idle", 32'(busy1), 32'd0);
        wait_drain(1, 20);

        // MUL_LAT=4, op1=7
        tick(); req4 = 2'b10; op1_4 = 32'd7; push4(2'b10, 32'd343);     // E0
        tick(); req4 = 2'b00;                                           // E1
        check("ml4_gnt",    32'(gnt4), 32'h2);
        check("ml4_idle_a", mul_a4,    32'd0);
        for (int k = 0; k < 4; k++) begin                               // E2..E5
            tick();
            check("ml4_sq_a", mul_a4, 32'd7);
            check("ml4_sq_b", mul_b4, 32'd7);
        end
        for (int k = 0; k < 4; k++) begin                               // E6..E9
            tick();
            check("ml4_cu_a",   mul_a4,     32'd49);
            check("ml4_cu_b",   mul_b4,     32'd7);
            check("ml4_nodone", 32'(done4), 32'd0);
        end
        tick();                                                         // E10
        check("ml4_done", 32'(done4), 32'h2);
        check("ml4_res",  result4,    32'd343);
        tick();                                                         // E11
        check("ml4_idle",   32'(busy4), 32'd0);
        check("ml4_mul_a0", mul_a4,     32'd0);
        wait_drain(4, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
